dma_burst_writer: RTL and testbench
===================================

# dma_burst_writer

Read side of the DMA block buffer. The block drains words from the dual-port SSRAM through one read port and writes them to the system bus as a sequence of write bursts. It handles bus arbitration, burst splitting, address advance and bus stall. It is the counterpart of the bus-to-buffer fill path, which writes the buffer through the other port.

## Interface
- `nrOfEntries`, 512, buffer depth in 32-bit words; `AW = $clog2(nrOfEntries)`.
- `maxBurst`, 16, maximum beats per bus burst (1..256).
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; honoured only in IDLE.
- `busStartAddress` in 32: first bus word address; bits [1:0] are ignored and treated as 0.
- `bufferStartAddress` in AW: first buffer entry.
- `blockSize` in AW+1: number of words to transfer, 0..nrOfEntries.
- `burstSize` in 8: beats per burst minus one; clamped to maxBurst-1.
- `busy` out 1: high from the cycle after an accepted start until DONE.
- `done` out 1: one-cycle pulse at completion.
- `error` out 1: sticky; cleared by the next accepted start.
- `bufferAddress` out AW: registered read address to the SSRAM.
- `bufferData` in 32: SSRAM read data.
- `requestBus` out 1: bus request.
- `busGrant` in 1: bus grant.
- `beginTransaction` out 1: one-cycle pulse that qualifies the address and burst outputs.
- `addressDataOut` out 32: address during beginTransaction, data during beats.
- `burstSizeOut` out 8: beats minus one of the current burst.
- `dataValid` out 1: a beat is presented.
- `busyIn` in 1: slave stall; a beat is accepted only when dataValid=1 and busyIn=0.
- `endTransaction` out 1: one-cycle pulse after the last beat.
- `busError` in 1: slave error.
- Reset values: busy, done, error, requestBus, beginTransaction, dataValid and endTransaction are 0. addressDataOut, burstSizeOut and bufferAddress are 0.

## Operation
- **States:** IDLE, REQUEST, BEGIN, DATA, CLOSE, FINISH.
- **IDLE:**
  - On start with blockSize≠0: latch the addresses and the remaining count `rem = blockSize`, then go to REQUEST.
  - On start with blockSize=0: pulse done without touching the bus and stay in IDLE.
- **REQUEST:**
  - Drive requestBus=1 and hold bufferAddress at the current entry, which prefetches the first word.
  - On busGrant=1, go to BEGIN.
- **BEGIN:**
  - One cycle with beginTransaction=1, addressDataOut=current bus address, burstSizeOut=beats-1.
  - `beats = min(rem, burstSize+1, maxBurst)`.
  - Next state is DATA.
- **DATA:**
  - dataValid=1 and addressDataOut=bufferData.
  - On each accepted beat: advance bufferAddress by 1, decrement the beat counter and rem.
  - While busyIn=1: hold bufferAddress, so the data stays stable.
  - After the last beat is accepted, go to CLOSE.
- **CLOSE:**
  - One cycle with endTransaction=1 and requestBus=0.
  - Bus address advances by 4·beats.
  - If rem≠0, go to REQUEST (re-arbitrate for every burst); otherwise go to FINISH.
- **FINISH:** pulse done, drop busy, return to IDLE.
- **Address wrap:**
  - bufferAddress wraps modulo nrOfEntries.
  - The bus address wraps modulo 2^32, with no boundary splitting.
- **busError in REQUEST..CLOSE:**
  - Drop requestBus and dataValid the next cycle and pulse endTransaction once.
  - Set error, pulse done, go to IDLE; the remaining words are abandoned.
- **start while busy:** ignored.
- **reset mid-burst:** outputs return to their reset values immediately; no endTransaction is issued.

## Timing
- **Buffer read latency:** a bufferAddress register value updated at edge N yields valid bufferData at edge N+1. The prefetch in REQUEST/BEGIN guarantees the first beat is valid on entering DATA.
- **Best-case burst length:** a burst with grant in the first REQUEST cycle and no stalls occupies 1 (REQUEST) + 1 (BEGIN) + beats + 1 (CLOSE) cycles.
- **start to done:** minimum for a single-burst block is beats+4 cycles.
- **Beat acceptance:** exactly one word per cycle in which dataValid=1 and busyIn=0; no beat is duplicated or skipped across a stall.
- **Output pulses:** done, beginTransaction and endTransaction are single-cycle and registered.

## Structure
- **Shared package `dma_pkg`:**
  - State enum.
  - Bus width constant, 32.
  - Burst encoding helper: beats = burstSize+1.
- **Sub-module `dma_burst_calc`:** natural place for the pure beats/next-address arithmetic. It is instantiated once.
- **Top level:** holds the FSM and counters. The SSRAM stays outside, connected via bufferAddress/bufferData.

## Test plan
- **Single burst:** blockSize=4, burstSize=3, busStartAddress=0x1000, buffer preloaded with 0xA0..0xA3, immediate grant, no stall.
  - One beginTransaction, address 0x1000, burstSizeOut=3.
  - Beats 0xA0..0xA3 on consecutive cycles, then endTransaction, then done at start+8.
- **Split bursts:** blockSize=10, burstSize=3 → three bursts of 4, 4, 2 beats, at addresses 0x1000, 0x1010, 0x1020, with requestBus released between bursts.
- **Stall:** busyIn high for 3 cycles on beat 2 → beat 2 is held stable 4 cycles; the sequence 0xA0..0xA3 is unchanged; done is delayed by 3 cycles.
- **Buffer wrap and size zero:**
  - bufferStartAddress=510, blockSize=4 → reads entries 510, 511, 0, 1.
  - blockSize=0 → done the cycle after start, requestBus never asserted.
- **Error:** busError during beat 1 of a 4-beat burst → dataValid low the next cycle, one endTransaction, error=1, done pulse, return to IDLE; a new start clears error.
- **Reset:** async reset asserted mid-DATA → all outputs 0 without waiting for a clock edge; a start after release runs normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA buffer-to-bus write path.
package dma_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_DATA,
    ST_CLOSE,
    ST_FINISH
  } dma_state_e;

  // Bus burst encoding: the size field carries beats minus one.
  function automatic logic [8:0] beats_from_size(input logic [7:0] burst_size);
    return 9'(burst_size) + 9'd1;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Pure burst arithmetic: beats of the next burst and the bus address after the current one.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [CNT_W-1:0] rem,
  input  logic [7:0]       burst_size,
  input  logic [CNT_W-1:0] cur_beats,
  input  logic [BUS_W-1:0] bus_addr,
  output logic [CNT_W-1:0] beats,
  output logic [BUS_W-1:0] next_addr
);

  localparam logic [7:0] MAX_BS = 8'(MAX_BURST - 1);

  logic [7:0]       bs_clamped;
  logic [CNT_W-1:0] burst_beats;

  always_comb begin
    bs_clamped  = (burst_size > MAX_BS) ? MAX_BS : burst_size;
    burst_beats = CNT_W'(beats_from_size(bs_clamped));
    beats       = (rem < burst_beats) ? rem : burst_beats;
    // Word addresses: each beat moves the bus address by four bytes, wrapping at 2^32.
    next_addr   = bus_addr + (BUS_W'(cur_beats) << 2);
  end

endmodule

// File: rtl/dma_burst_writer.sv
// DMA buffer-to-bus path: drains SSRAM words onto the system bus as arbitrated write bursts.
module dma_burst_writer
  import dma_pkg::*;
#(
  parameter int unsigned nrOfEntries = 512,
  parameter int unsigned maxBurst    = 16,
  localparam int unsigned AW         = $clog2(nrOfEntries)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BUS_W-1:0] busStartAddress,
  input  logic [AW-1:0]    bufferStartAddress,
  input  logic [AW:0]      blockSize,
  input  logic [7:0]       burstSize,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AW-1:0]    bufferAddress,
  input  logic [BUS_W-1:0] bufferData,
  output logic             requestBus,
  input  logic             busGrant,
  output logic             beginTransaction,
  output logic [BUS_W-1:0] addressDataOut,
  output logic [7:0]       burstSizeOut,
  output logic             dataValid,
  input  logic             busyIn,
  output logic             endTransaction,
  input  logic             busError
);

  localparam int unsigned CNT_W = (AW + 1 > 9) ? AW + 1 : 9;

  dma_state_e       state_q, state_d;
  logic [BUS_W-1:0] bus_addr_q, bus_addr_d;
  logic [AW-1:0]    buf_addr_q, buf_addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]       burst_size_q, burst_size_d;
  logic [BUS_W-1:0] addr_out_q, addr_out_d;
  logic [7:0]       burst_out_q, burst_out_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic             req_q, req_d, begin_txn_q, begin_txn_d;
  logic             dv_q, dv_d, end_txn_q, end_txn_d;
  logic             abort_end;
  logic [CNT_W-1:0] calc_beats;
  logic [BUS_W-1:0] calc_next_addr;

  dma_burst_calc #(
    .CNT_W    (CNT_W),
    .MAX_BURST(maxBurst)
  ) u_calc (
    .rem       (rem_q),
    .burst_size(burst_size_q),
    .cur_beats (beats_q),
    .bus_addr  (bus_addr_q),
    .beats     (calc_beats),
    .next_addr (calc_next_addr)
  );

  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    buf_addr_d   = buf_addr_q;
    rem_d        = rem_q;
    beats_d      = beats_q;
    beat_cnt_d   = beat_cnt_q;
    burst_size_d = burst_size_q;
    addr_out_d   = '0;
    burst_out_d  = burst_out_q;
    error_d      = error_q;
    done_d       = 1'b0;
    abort_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (blockSize == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_REQUEST;
            bus_addr_d   = busStartAddress & ~BUS_W'(3);
            buf_addr_d   = bufferStartAddress;
            rem_d        = CNT_W'(blockSize);
            burst_size_d = burstSize;
          end
        end
      end
      ST_REQUEST: begin
        if (busError) begin
          state_d   = ST_FINISH;
          error_d   = 1'b1;
          abort_end = 1'b1;
        end else if (busGrant) begin
          state_d     = ST_BEGIN;
          addr_out_d  = bus_addr_q;
          beats_d     = calc_beats;
          beat_cnt_d  = calc_beats;
          burst_out_d = 8'(calc_beats - CNT_W'(1));
        end
      end
      ST_BEGIN: begin
        if (busError) begin
          state_d   = ST_FINISH;
          error_d   = 1'b1;
          abort_end = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (busError) begin
          state_d   = ST_FINISH;
          error_d   = 1'b1;
          abort_end = 1'b1;
        end else if (!busyIn) begin
          // Advancing only on acceptance keeps the read data stable through a stall.
          buf_addr_d = buf_addr_q + AW'(1);
          rem_d      = rem_q - CNT_W'(1);
          beat_cnt_d = beat_cnt_q - CNT_W'(1);
          if (beat_cnt_q == CNT_W'(1)) state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        bus_addr_d = calc_next_addr;
        if (busError) begin
          state_d = ST_FINISH;
          error_d = 1'b1;
        end else begin
          state_d = (rem_q != '0) ? ST_REQUEST : ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    req_d       = state_d inside {ST_REQUEST, ST_BEGIN, ST_DATA};
    busy_d      = state_d inside {ST_REQUEST, ST_BEGIN, ST_DATA, ST_CLOSE};
    begin_txn_d = (state_d == ST_BEGIN);
    dv_d        = (state_d == ST_DATA);
    end_txn_d   = (state_d == ST_CLOSE) || abort_end;
    done_d      = done_d || (state_d == ST_FINISH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bus_addr_q   <= '0;
      buf_addr_q   <= '0;
      rem_q        <= '0;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      burst_size_q <= '0;
      addr_out_q   <= '0;
      burst_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      req_q        <= 1'b0;
      begin_txn_q  <= 1'b0;
      dv_q         <= 1'b0;
      end_txn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      buf_addr_q   <= buf_addr_d;
      rem_q        <= rem_d;
      beats_q      <= beats_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_size_q <= burst_size_d;
      addr_out_q   <= addr_out_d;
      burst_out_q  <= burst_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      req_q        <= req_d;
      begin_txn_q  <= begin_txn_d;
      dv_q         <= dv_d;
      end_txn_q    <= end_txn_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign bufferAddress    = buf_addr_q;
  assign requestBus       = req_q;
  assign beginTransaction = begin_txn_q;
  assign burstSizeOut     = burst_out_q;
  assign dataValid        = dv_q;
  assign endTransaction   = end_txn_q;
  // Beats come straight from the SSRAM port; the address phase comes from its own register.
  assign addressDataOut   = dv_q ? bufferData : addr_out_q;

endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: SSRAM model, immediate-grant bus slave, cycle-indexed monitor.
module tb_dma_burst_writer;

  localparam int unsigned N  = 512;
  localparam int unsigned AW = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   busStartAddress = '0;
  logic [AW-1:0] bufferStartAddress = '0;
  logic [AW:0]   blockSize = '0;
  logic [7:0]    burstSize = '0;
  logic          busy, done, error, requestBus, beginTransaction, dataValid, endTransaction;
  logic [AW-1:0] bufferAddress;
  logic [31:0]   bufferData, addressDataOut;
  logic [7:0]    burstSizeOut;
  logic          busGrant, busyIn, busError;

  logic          stall_en = 1'b0;
  logic          err_en   = 1'b0;
  int            acc_cnt, stall_left;
  logic [31:0]   mem [N];

  int            n_cmp = 0;
  int            n_err = 0;

  int            cyc, done_cnt, done_cyc, end_cnt, end_cyc, req_rise;
  logic          req_prev;
  logic [31:0]   beg_addr[$], beg_bsz[$], beat_data[$], dv_data[$];
  int            dv_cyc[$];

  dma_burst_writer #(.nrOfEntries(N), .maxBurst(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busStartAddress(busStartAddress), .bufferStartAddress(bufferStartAddress),
    .blockSize(blockSize), .burstSize(burstSize),
    .busy(busy), .done(done), .error(error),
    .bufferAddress(bufferAddress), .bufferData(bufferData),
    .requestBus(requestBus), .busGrant(busGrant),
    .beginTransaction(beginTransaction), .addressDataOut(addressDataOut),
    .burstSizeOut(burstSizeOut), .dataValid(dataValid), .busyIn(busyIn),
    .endTransaction(endTransaction), .busError(busError)
  );

  always #5 clock = ~clock;

  // SSRAM read port: data follows the registered address one edge later.
  assign bufferData = mem[bufferAddress];
  assign busGrant   = requestBus;
  assign busyIn     = stall_en && dataValid && (acc_cnt == 2) && (stall_left != 0);
  assign busError   = err_en && dataValid && (acc_cnt == 1);

  always @(posedge clock) begin
    if (start) begin
      acc_cnt    <= 0;
      stall_left <= 3;
    end else if (dataValid) begin
      if (!busyIn) acc_cnt <= acc_cnt + 1;
      else         stall_left <= stall_left - 1;
    end
  end

  // Cycle 0 is the cycle in which start is high.
  always @(negedge clock) begin
    if (start) begin
      cyc <= 1; done_cnt <= 0; done_cyc <= 0; end_cnt <= 0; end_cyc <= 0; req_rise <= 0;
      beg_addr.delete(); beg_bsz.delete(); beat_data.delete(); dv_data.delete(); dv_cyc.delete();
    end else begin
      cyc <= cyc + 1;
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (endTransaction) begin end_cnt <= end_cnt + 1; end_cyc <= cyc; end
      if (requestBus && !req_prev) req_rise <= req_rise + 1;
      if (beginTransaction) begin
        beg_addr.push_back(addressDataOut);
        beg_bsz.push_back(32'(burstSizeOut));
      end
      if (dataValid) begin
        dv_data.push_back(addressDataOut);
        dv_cyc.push_back(cyc);
        if (!busyIn) beat_data.push_back(addressDataOut);
      end
    end
    req_prev <= requestBus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] ba, input logic [AW-1:0] bufa,
                             input logic [AW:0] sz, input logic [7:0] bs);
    @(posedge clock); #1;
    busStartAddress    = ba;
    bufferStartAddress = bufa;
    blockSize          = sz;
    burstSize          = bs;
    start              = 1'b1;
    @(posedge clock); #1;
    start              = 1'b0;
  endtask

  task automatic run(input logic [31:0] ba, input logic [AW-1:0] bufa,
                     input logic [AW:0] sz, input logic [7:0] bs);
    pulse_start(ba, bufa, sz, bs);
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("done_once", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(N); i++) mem[i] = 32'hA0 + 32'(i);
    mem[510] = 32'hB0;
    mem[511] = 32'hB1;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(requestBus), 32'd0);
    check("rst_ado", addressDataOut, 32'd0);
    #20 reset = 1'b0;

    // Single 4-beat burst
    run(32'h1000, 9'd0, 10'd4, 8'd3);
    check("s_nbeg", 32'(beg_addr.size()), 32'd1);
    check("s_addr", beg_addr[0], 32'h1000);
    check("s_bsz", beg_bsz[0], 32'd3);
    check("s_nbeat", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("s_beat", beat_data[i], 32'hA0 + 32'(i));
    check("s_first_dv", 32'(dv_cyc[0]), 32'd3);
    check("s_end_cyc", 32'(end_cyc), 32'd7);
    check("s_done_cyc", 32'(done_cyc), 32'd8);
    check("s_busy_after", 32'(busy), 32'd0);

    // Split into 4 + 4 + 2
    run(32'h1000, 9'd0, 10'd10, 8'd3);
    check("p_nbeg", 32'(beg_addr.size()), 32'd3);
    check("p_addr1", beg_addr[1], 32'h1010);
    check("p_addr2", beg_addr[2], 32'h1020);
    check("p_bsz2", beg_bsz[2], 32'd1);
    check("p_req_rise", 32'(req_rise), 32'd3);
    check("p_nend", 32'(end_cnt), 32'd3);
    check("p_nbeat", 32'(beat_data.size()), 32'd10);
    check("p_last", beat_data[9], 32'hA9);
    check("p_done_cyc", 32'(done_cyc), 32'd20);

    // Three-cycle stall on beat 2
    stall_en = 1'b1;
    run(32'h1000, 9'd0, 10'd4, 8'd3);
    stall_en = 1'b0;
    check("t_ndv", 32'(dv_data.size()), 32'd7);
    for (int i = 2; i < 6; i++) check("t_held", dv_data[i], 32'hA2);
    check("t_nbeat", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t_beat", beat_data[i], 32'hA0 + 32'(i));
    check("t_done_cyc", 32'(done_cyc), 32'd11);

    // Buffer wrap at 512
    run(32'h3000, 9'd510, 10'd4, 8'd7);
    check("w_b0", beat_data[0], 32'hB0);
    check("w_b1", beat_data[1], 32'hB1);
    check("w_b2", beat_data[2], 32'hA0);
    check("w_b3", beat_data[3], 32'hA1);

    // Block size zero
    run(32'h1000, 9'd0, 10'd0, 8'd3);
    check("z_done_cyc", 32'(done_cyc), 32'd1);
    check("z_req", 32'(req_rise), 32'd0);
    check("z_nbeg", 32'(beg_addr.size()), 32'd0);

    // Burst size clamped to maxBurst, low address bits ignored
    run(32'h2003, 9'd0, 10'd20, 8'd255);
    check("c_addr0", beg_addr[0], 32'h2000);
    check("c_bsz0", beg_bsz[0], 32'd15);
    check("c_addr1", beg_addr[1], 32'h2040);
    check("c_bsz1", beg_bsz[1], 32'd3);
    check("c_last", beat_data[19], 32'hB3);
    check("c_done_cyc", 32'(done_cyc), 32'd27);

    // Bus address wraps through 2^32
    run(32'hFFFF_FFFC, 9'd0, 10'd2, 8'd0);
    check("a_addr0", beg_addr[0], 32'hFFFF_FFFC);
    check("a_addr1", beg_addr[1], 32'h0000_0000);
    check("a_done_cyc", 32'(done_cyc), 32'd9);

    // Bus error on beat 1
    err_en = 1'b1;
    run(32'h1000, 9'd0, 10'd4, 8'd3);
    err_en = 1'b0;
    check("e_ndv", 32'(dv_data.size()), 32'd2);
    check("e_nend", 32'(end_cnt), 32'd1);
    check("e_end_cyc", 32'(end_cyc), 32'd5);
    check("e_done_cyc", 32'(done_cyc), 32'd5);
    check("e_error", 32'(error), 32'd1);
    check("e_busy", 32'(busy), 32'd0);
    run(32'h1000, 9'd0, 10'd4, 8'd3);
    check("e_cleared", 32'(error), 32'd0);
    check("e_rerun_beat3", beat_data[3], 32'hA3);

    // Asynchronous reset in the middle of DATA
    pulse_start(32'h1000, 9'd0, 10'd4, 8'd3);
    repeat (3) @(posedge clock);
    #3;
    check("r_pre_dv", 32'(dataValid), 32'd1);
    check("r_pre_ado", addressDataOut, 32'hA1);
    reset = 1'b1;
    #1;
    check("r_dv", 32'(dataValid), 32'd0);
    check("r_req", 32'(requestBus), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_ado", addressDataOut, 32'd0);
    check("r_bufa", 32'(bufferAddress), 32'd0);
    check("r_bsz", 32'(burstSizeOut), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("r_noend", 32'(end_cnt), 32'd0);
    run(32'h1000, 9'd0, 10'd4, 8'd3);
    check("r_after_n", 32'(beat_data.size()), 32'd4);
    check("r_after_b0", beat_data[0], 32'hA0);
    check("r_after_done", 32'(done_cyc), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
